vpifo_task_dispatch: RTL and testbench

- Parametrised front-end for the virtualised SRAM PIFO ring: PORT_NUM task ingress ports, each with its own task FIFO, feeding LEVEL ring RPUs.
- Successor to the fixed per-level TaskFIFO + distributor pairing: port count is decoupled from LEVEL; per-RPU round-robin arbitration across ports.
- Ring-slot reservation table guarantees an injected operation never collides with in-flight operations circulating the ring.
- Per-tree cooldown blocks back-to-back root accesses to the same tree.

---
 rtl/vpifo_task_dispatch.sv | 256 +++++++++++++++++++++++++
 tb/tb_vpifo_task_dispatch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vpifo_task_dispatch.sv
// vpifo_task_dispatch
// Front-end for the virtualised SRAM PIFO ring. PORT_NUM ingress ports each
// own a task FIFO. Every ring RPU picks one eligible port head round-robin.
// A head is eligible only when its injection slot is free of in-flight ring
// traffic and its tree is not in cooldown.
//
// Ports:
//   i_clk, i_arst_n         clock, asynchronous active-low reset
//   i_task_valid/o_task_ready  per-port ingress handshake (ready = FIFO not full)
//   i_task_op               per port: 1 = push, 0 = pop
//   i_task_tree_id          per-port target tree (root RPU = tree % LEVEL)
//   i_task_data             per-port push payload (PTW+MTW bits)
//   o_rpu_push/o_rpu_pop    one-cycle injection strobes per RPU
//   o_rpu_tree_id           tree of the injected op per RPU
//   o_rpu_push_data         payload of the injected push (0 otherwise)
//   o_fifo_level            per-port FIFO occupancy
//   o_grant_cnt/o_stall_cnt statistics, present only with VPIFO_DISPATCH_STATS_EN
//
// Optional feature macro: VPIFO_DISPATCH_STATS_EN (per-RPU grant counters and
// a collision-stall counter; both outputs tie to 0 when undefined).
module vpifo_task_dispatch #(
  parameter int PTW       = 16,
  parameter int MTW       = 0,
  parameter int LEVEL     = 4,
  parameter int TREE_NUM  = 4,
  parameter int PORT_NUM  = 4,
  parameter int FIFO_SIZE = 8,
  parameter int STAGE_LAT = 2
) (
  input  logic                                        i_clk,
  input  logic                                        i_arst_n,
  input  logic [PORT_NUM-1:0]                         i_task_valid,
  output logic [PORT_NUM-1:0]                         o_task_ready,
  input  logic [PORT_NUM-1:0]                         i_task_op,
  input  logic [PORT_NUM*$clog2(TREE_NUM)-1:0]        i_task_tree_id,
  input  logic [PORT_NUM*(PTW+MTW)-1:0]               i_task_data,
  output logic [LEVEL-1:0]                            o_rpu_push,
  output logic [LEVEL-1:0]                            o_rpu_pop,
  output logic [LEVEL*$clog2(TREE_NUM)-1:0]           o_rpu_tree_id,
  output logic [LEVEL*(PTW+MTW)-1:0]                  o_rpu_push_data,
  output logic [PORT_NUM*($clog2(FIFO_SIZE)+1)-1:0]   o_fifo_level,
  output logic [LEVEL*16-1:0]                         o_grant_cnt,
  output logic [15:0]                                 o_stall_cnt
);
  localparam int TW   = $clog2(TREE_NUM);
  localparam int DW   = PTW + MTW;
  localparam int EW   = 1 + TW + DW;
  localparam int AW   = $clog2(FIFO_SIZE);
  localparam int CW   = AW + 1;
  localparam int LW   = $clog2(LEVEL);
  localparam int PW   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int ROWS = LEVEL * STAGE_LAT;
  localparam int CDW  = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;

  // Per-port FIFO storage and bookkeeping
  logic [EW-1:0]       mem_q    [PORT_NUM][FIFO_SIZE];
  logic [AW-1:0]       wr_ptr_q [PORT_NUM];
  logic [AW-1:0]       rd_ptr_q [PORT_NUM];
  logic [CW-1:0]       cnt_q    [PORT_NUM];
  logic [CW-1:0]       cnt_d    [PORT_NUM];
  logic [PORT_NUM-1:0] ready_q, ready_d, wr_en, rd_en;

  // Head decode
  logic [PORT_NUM-1:0] head_op;
  logic [TW-1:0]       head_tree [PORT_NUM];
  logic [DW-1:0]       head_data [PORT_NUM];
  logic [LW-1:0]       head_rpu  [PORT_NUM];
  logic [PORT_NUM-1:0] elig;

  // Reservation table: row i of the register is the slot map i+1 cycles
  // after the current one, so row 0 of next state is what eligibility sees.
  logic [ROWS*LEVEL-1:0] res_q, res_d;
  logic [LEVEL-1:0]      res_now;
  logic [CDW-1:0]        cd_q [TREE_NUM];
  logic [CDW-1:0]        cd_d [TREE_NUM];

  // Arbitration and registered injection outputs
  logic [PW-1:0]    rr_q [LEVEL];
  logic [PW-1:0]    rr_d [LEVEL];
  logic [PW-1:0]    win  [LEVEL];
  logic [LEVEL-1:0] grant;
  logic [LEVEL-1:0] push_q, push_d, pop_q, pop_d;
  logic [TW-1:0]    tree_q [LEVEL];
  logic [TW-1:0]    tree_d [LEVEL];
  logic [DW-1:0]    data_q [LEVEL];
  logic [DW-1:0]    data_d [LEVEL];

  function automatic int rr_idx(input int base, input int off);
    return (base + off) % PORT_NUM;
  endfunction

  assign res_now = res_q[LEVEL-1:0];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      {head_op[p], head_tree[p], head_data[p]} = mem_q[p][rd_ptr_q[p]];
      head_rpu[p] = LW'(int'(head_tree[p]) % LEVEL);
      elig[p]     = (cnt_q[p] != '0) && (cd_q[head_tree[p]] == '0) &&
                    !res_now[head_rpu[p]];
    end
  end

  // Per-RPU round robin. Scanning from the far end down to the pointer lets
  // the last hit (closest to the pointer) win without a found flag. Each port
  // targets exactly one RPU, so it can win at most once per cycle.
  always_comb begin
    grant = '0;
    rd_en = '0;
    for (int r = 0; r < LEVEL; r++) begin
      rr_d[r] = rr_q[r];
      win[r]  = '0;
      for (int i = PORT_NUM - 1; i >= 0; i--) begin
        if (elig[rr_idx(int'(rr_q[r]), i)] &&
            head_rpu[rr_idx(int'(rr_q[r]), i)] == LW'(r)) begin
          grant[r] = 1'b1;
          win[r]   = PW'(rr_idx(int'(rr_q[r]), i));
        end
      end
      if (grant[r]) begin
        rd_en[win[r]] = 1'b1;
        rr_d[r]       = PW'(rr_idx(int'(win[r]), 1));
      end
    end
  end

  // Grant side effects: injection outputs, tree cooldown, ring reservations
  always_comb begin
    res_d = {{LEVEL{1'b0}}, res_q[ROWS*LEVEL-1:LEVEL]};
    for (int t = 0; t < TREE_NUM; t++)
      cd_d[t] = (cd_q[t] != '0) ? cd_q[t] - CDW'(1) : '0;
    for (int r = 0; r < LEVEL; r++) begin
      push_d[r] = 1'b0;
      pop_d[r]  = 1'b0;
      tree_d[r] = '0;
      data_d[r] = '0;
      if (grant[r]) begin
        push_d[r] = head_op[win[r]];
        pop_d[r]  = !head_op[win[r]];
        tree_d[r] = head_tree[win[r]];
        data_d[r] = head_op[win[r]] ? head_data[win[r]] : '0;
        // Cooldown counts remaining blocked cycles; a grant at g frees the
        // tree again at g+STAGE_LAT.
        cd_d[head_tree[win[r]]] = CDW'(STAGE_LAT - 1);
        // The op reaches RPU r+k k*STAGE_LAT cycles from now, which is
        // register row k*STAGE_LAT-1.
        for (int k = 1; k < LEVEL; k++)
          res_d[(k*STAGE_LAT - 1)*LEVEL + (r + k) % LEVEL] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      wr_en[p]   = i_task_valid[p] & ready_q[p];
      cnt_d[p]   = cnt_q[p] + CW'(wr_en[p]) - CW'(rd_en[p]);
      ready_d[p] = (cnt_d[p] != CW'(FIFO_SIZE));
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process order.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ready_q <= '1;
      res_q   <= '0;
      push_q  <= '0;
      pop_q   <= '0;
      for (int p = 0; p < PORT_NUM; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
      end
      for (int t = 0; t < TREE_NUM; t++) cd_q[t] <= '0;
      for (int r = 0; r < LEVEL; r++) begin
        rr_q[r]   <= '0;
        tree_q[r] <= '0;
        data_q[r] <= '0;
      end
    end else begin
      ready_q <= ready_d;
      res_q   <= res_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      for (int p = 0; p < PORT_NUM; p++) begin
        if (wr_en[p]) wr_ptr_q[p] <= wr_ptr_q[p] + AW'(1);
        if (rd_en[p]) rd_ptr_q[p] <= rd_ptr_q[p] + AW'(1);
        cnt_q[p] <= cnt_d[p];
      end
      for (int t = 0; t < TREE_NUM; t++) cd_q[t] <= cd_d[t];
      for (int r = 0; r < LEVEL; r++) begin
        rr_q[r]   <= rr_d[r];
        tree_q[r] <= tree_d[r];
        data_q[r] <= data_d[r];
      end
    end
  end

  // NOTE: FIFO storage has no reset; the counters and pointers alone decide
  // which entries are valid, so clearing the array would only cost area.
  always_ff @(posedge i_clk) begin
    for (int p = 0; p < PORT_NUM; p++)
      if (wr_en[p])
        mem_q[p][wr_ptr_q[p]] <= {i_task_op[p], i_task_tree_id[p*TW +: TW],
                                  i_task_data[p*DW +: DW]};
  end

  assign o_task_ready = ready_q;
  assign o_rpu_push   = push_q;
  assign o_rpu_pop    = pop_q;

  for (genvar r = 0; r < LEVEL; r++) begin : g_out
    assign o_rpu_tree_id[r*TW +: TW]   = tree_q[r];
    assign o_rpu_push_data[r*DW +: DW] = data_q[r];
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_lvl
    assign o_fifo_level[p*CW +: CW] = cnt_q[p];
  end

`ifdef VPIFO_DISPATCH_STATS_EN
  logic [15:0] gcnt_q [LEVEL];
  logic [15:0] stall_q;
  logic        stall_hit;

  // A head counts as a collision stall only when the reservation slot is the
  // sole reason it cannot go this cycle.
  always_comb begin
    stall_hit = 1'b0;
    for (int p = 0; p < PORT_NUM; p++)
      if ((cnt_q[p] != '0) && (cd_q[head_tree[p]] == '0) && res_now[head_rpu[p]])
        stall_hit = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      stall_q <= '0;
      for (int r = 0; r < LEVEL; r++) gcnt_q[r] <= '0;
    end else begin
      if (stall_hit && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      for (int r = 0; r < LEVEL; r++)
        if (grant[r] && gcnt_q[r] != 16'hFFFF) gcnt_q[r] <= gcnt_q[r] + 16'd1;
    end
  end

  for (genvar r = 0; r < LEVEL; r++) begin : g_gcnt
    assign o_grant_cnt[r*16 +: 16] = gcnt_q[r];
  end
  assign o_stall_cnt = stall_q;
`else
  assign o_grant_cnt = '0;
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vpifo_task_dispatch.sv
// Testbench for vpifo_task_dispatch (LEVEL=4, TREE_NUM=4, PORT_NUM=4,
// FIFO_SIZE=8, STAGE_LAT=2). Stimulus pushes expected injections into a
// scoreboard queue; a monitor compares every injection the DUT presents.
module tb_vpifo_task_dispatch;
  localparam int PTW = 16, MTW = 0, LEVEL = 4, TREE_NUM = 4;
  localparam int PORT_NUM = 4, FIFO_SIZE = 8, STAGE_LAT = 2;
  localparam int TW = 2, DW = 16, CW = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [PORT_NUM-1:0]     i_task_valid, o_task_ready, i_task_op;
  logic [PORT_NUM*TW-1:0]  i_task_tree_id;
  logic [PORT_NUM*DW-1:0]  i_task_data;
  logic [LEVEL-1:0]        o_rpu_push, o_rpu_pop;
  logic [LEVEL*TW-1:0]     o_rpu_tree_id;
  logic [LEVEL*DW-1:0]     o_rpu_push_data;
  logic [PORT_NUM*CW-1:0]  o_fifo_level;
  logic [LEVEL*16-1:0]     o_grant_cnt;
  logic [15:0]             o_stall_cnt;

  vpifo_task_dispatch #(
    .PTW(PTW), .MTW(MTW), .LEVEL(LEVEL), .TREE_NUM(TREE_NUM),
    .PORT_NUM(PORT_NUM), .FIFO_SIZE(FIFO_SIZE), .STAGE_LAT(STAGE_LAT)
  ) dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_task_valid(i_task_valid), .o_task_ready(o_task_ready),
    .i_task_op(i_task_op), .i_task_tree_id(i_task_tree_id),
    .i_task_data(i_task_data),
    .o_rpu_push(o_rpu_push), .o_rpu_pop(o_rpu_pop),
    .o_rpu_tree_id(o_rpu_tree_id), .o_rpu_push_data(o_rpu_push_data),
    .o_fifo_level(o_fifo_level), .o_grant_cnt(o_grant_cnt),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;   // -1: cycle not checked
    int          rpu;
    bit          push;
    int          tree;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic put(input int p, input bit op, input int tree, input logic [15:0] data);
    i_task_valid[p]           = 1'b1;
    i_task_op[p]              = op;
    i_task_tree_id[p*TW +: TW] = TW'(tree);
    i_task_data[p*DW +: DW]   = data;
  endtask

  task automatic expect_op(input int c, input int r, input bit push, input int tree,
                           input logic [15:0] data);
    exp_t e;
    e.cyc = c; e.rpu = r; e.push = push; e.tree = tree; e.data = data;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    i_task_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d injections still outstanding after %0d cycles",
               sb.size(), budget);
    end
  endtask

  // Monitor: samples registered outputs on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int r = 0; r < LEVEL; r++) begin
        check("push_pop_excl", 64'(o_rpu_push[r] & o_rpu_pop[r]), 64'd0);
        if (!o_rpu_push[r]) check("idle_data", 64'(o_rpu_push_data[r*DW +: DW]), 64'd0);
        if (o_rpu_push[r] || o_rpu_pop[r]) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_op: rpu %0d push %0b pop %0b at cycle %0d, none expected",
                     r, o_rpu_push[r], o_rpu_pop[r], cyc);
          end else begin
            e = sb.pop_front();
            if (e.cyc >= 0) check("op_cycle", 64'(cyc), 64'(e.cyc));
            check("op_rpu", 64'(r), 64'(e.rpu));
            check("op_push", 64'(o_rpu_push[r]), 64'(e.push));
            check("op_tree", 64'(o_rpu_tree_id[r*TW +: TW]), 64'(e.tree));
            check("op_data", 64'(o_rpu_push_data[r*DW +: DW]), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    i_task_valid   = '0;
    i_task_op      = '0;
    i_task_tree_id = '0;
    i_task_data    = '0;
    rst_n          = 1'b0;
    idle(2);

    // Reset state
    check("rst_ready", 64'(o_task_ready), 64'hF);
    check("rst_level", 64'(o_fifo_level), 64'h0);
    check("rst_push", 64'(o_rpu_push), 64'h0);
    check("rst_pop", 64'(o_rpu_pop), 64'h0);
    check("rst_stall_cnt", 64'(o_stall_cnt), 64'h0);
    check("rst_grant_cnt", 64'(o_grant_cnt), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // 1: single push, two-cycle latency
    t0 = cyc;
    put(0, 1'b1, 0, 16'h0011);
    expect_op(t0 + 2, 0, 1'b1, 0, 16'h0011);
    step();
    check("t1_level_a", 64'(o_fifo_level[3:0]), 64'd1);
    @(negedge clk);
    check("t1_level_b", 64'(o_fifo_level[3:0]), 64'd0);
    wait_drain(20);
    idle(10);

    // 2: reservation from RPU0 grant delays pop on RPU1 by one cycle
    t0 = cyc;
    put(0, 1'b1, 0, 16'h0022);
    expect_op(t0 + 2, 0, 1'b1, 0, 16'h0022);
    step();
    step();
    put(1, 1'b0, 1, 16'hBEEF);
    expect_op(t0 + 5, 1, 1'b0, 1, 16'h0000);
    step();
    wait_drain(20);
    idle(10);
`ifdef VPIFO_DISPATCH_STATS_EN
    check("t2_stall_cnt", 64'(o_stall_cnt), 64'd1);
`else
    check("t2_stall_cnt_off", 64'(o_stall_cnt), 64'd0);
`endif

    // 3: four ports on tree2, cooldown spaces grants by two, order 0..3
    t0 = cyc;
    for (int p = 0; p < PORT_NUM; p++) begin
      put(p, 1'b1, 2, 16'h0300 + 16'(p));
      expect_op(t0 + 2 + 2*p, 2, 1'b1, 2, 16'h0300 + 16'(p));
    end
    step();
    wait_drain(30);
    idle(10);
`ifdef VPIFO_DISPATCH_STATS_EN
    check("t3_grant_cnt2", 64'(o_grant_cnt[2*16 +: 16]), 64'd4);
`else
    check("t3_grant_cnt_off", 64'(o_grant_cnt), 64'd0);
`endif

    // 4: fill port3 while every slot is held reserved; 9th push dropped
    force dut.res_q = '1;
    for (int i = 0; i < 9; i++) begin
      put(3, 1'b1, 3, 16'h0400 + 16'(i));
      if (i < 8) expect_op(-1, 3, 1'b1, 3, 16'h0400 + 16'(i));
      step();
      check("t4_ready", 64'(o_task_ready[3]), (i < 7) ? 64'd1 : 64'd0);
      check("t4_level", 64'(o_fifo_level[15:12]), (i < 8) ? 64'(i + 1) : 64'd8);
    end
    release dut.res_q;
    wait_drain(60);
    idle(12);

    // 5: two RPUs granted in the same cycle
    t0 = cyc;
    put(0, 1'b1, 1, 16'h0051);
    put(1, 1'b1, 3, 16'h0053);
    expect_op(t0 + 2, 1, 1'b1, 1, 16'h0051);
    expect_op(t0 + 2, 3, 1'b1, 3, 16'h0053);
    step();
    wait_drain(20);
    idle(10);

    // 6: reset with five queued tasks
    force dut.res_q = '1;
    for (int p = 0; p < PORT_NUM; p++) put(p, 1'b1, 0, 16'h0600 + 16'(p));
    step();
    put(0, 1'b1, 0, 16'h0604);
    step();
    check("t6_level_pre", 64'(o_fifo_level), 64'h1112);
    rst_n = 1'b0;
    #1;
    check("t6_rst_level", 64'(o_fifo_level), 64'h0);
    check("t6_rst_ready", 64'(o_task_ready), 64'hF);
    check("t6_rst_push", 64'(o_rpu_push), 64'h0);
    check("t6_rst_pop", 64'(o_rpu_pop), 64'h0);
    check("t6_rst_tree", 64'(o_rpu_tree_id), 64'h0);
    check("t6_rst_data", 64'(o_rpu_push_data), 64'h0);
    release dut.res_q;
    idle(2);
    rst_n = 1'b1;
    idle(20);
    check("t6_post_level", 64'(o_fifo_level), 64'h0);
    check("t6_post_ready", 64'(o_task_ready), 64'hF);

    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d injections never observed", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
